// File: rtl/multiplier_seq_if.sv
// Operand/result handshake bundle for multiplier_seq.
// Carries the ovf flag only when MULT_SEQ_OVF_EN is defined.
interface multiplier_seq_if #(
  parameter int W = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
`ifdef MULT_SEQ_OVF_EN
  logic           ovf;

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product, ovf
  );

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product, ovf
  );
`else
  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product
  );

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product
  );
`endif
endinterface

// File: rtl/multiplier_seq.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, W/2+1 cycles per product.
// Optional overflow flag enabled by defining MULT_SEQ_OVF_EN.
module multiplier_seq #(
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          rst,
  multiplier_seq_if.slave bus
);

  localparam int N  = W / 2 + 1;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_d;
  logic [2*W-1:0] mcand_q;
  logic [2*W-1:0] pp;
  logic [2*W-1:0] product_q;
  logic [W+1:0]   mplier_q;
  logic           prev_q;
  logic           accept;
  logic           last;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign last   = (state_q == BUSY) && (cnt_q == CW'(N - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Booth digit from {b[2i+1], b[2i], b[2i-1]}; arithmetic is mod 2^(2W),
  // which is exact for the truncated 2W-bit result.
  always_comb begin
    pp = '0;
    case ({mplier_q[1:0], prev_q})
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  assign acc_d = acc_q + pp;

  // NOTE: operand shift registers carry no reset; they are always loaded on
  // accept before being read, so only control and visible outputs reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      mcand_q  <= bus.is_signed ? {{W{bus.a[W-1]}}, bus.a} : {{W{1'b0}}, bus.a};
      mplier_q <= {{2{bus.is_signed & bus.b[W-1]}}, bus.b};
      prev_q   <= 1'b0;
    end else if (state_q == BUSY) begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_q + 1'b1;
      mcand_q  <= mcand_q << 2;
      mplier_q <= mplier_q >> 2;
      prev_q   <= mplier_q[1];
      if (last) product_q <= acc_d;
    end
  end

  assign bus.product = product_q;

`ifdef MULT_SEQ_OVF_EN
  logic signed_q;
  logic ovf_q;
  logic ovf_d;

  // Signed fit needs the top W+1 bits to be one sign; unsigned needs top W zero.
  assign ovf_d = signed_q ? !((&acc_d[2*W-1:W-1]) || !(|acc_d[2*W-1:W-1]))
                          : (|acc_d[2*W-1:W]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      signed_q <= bus.is_signed;
    end else if (last) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench for multiplier_seq: W=32 vectors, corner sequences and
// random ops, plus an exhaustive W=8 sweep spread across parallel instances.
module tb_multiplier_seq;

  localparam int W = 32;
  localparam int N = W / 2 + 1;
  localparam int L = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  multiplier_seq_if #(.W(W)) mif ();
  multiplier_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(mif));

  // W=8 lanes run in lock-step so the exhaustive sweep stays short.
  logic [7:0]  l_a    [L];
  logic [7:0]  l_b    [L];
  logic [15:0] l_prod [L];
  logic        l_ov   [L];
  logic        l_s;
  logic        l_iv;
  logic        l_or;

  for (genvar g = 0; g < L; g++) begin : lane
    multiplier_seq_if #(.W(8)) lif ();
    assign lif.in_valid  = l_iv;
    assign lif.a         = l_a[g];
    assign lif.b         = l_b[g];
    assign lif.is_signed = l_s;
    assign lif.out_ready = l_or;
    assign l_prod[g]     = lif.product;
    assign l_ov[g]       = lif.out_valid;
    multiplier_seq #(.W(8)) u_mul (.clk(clk), .rst(rst), .bus(lif));
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint px, py;
    if (s) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'({32'b0, x});
      py = longint'({32'b0, y});
    end
    return 64'(px * py);
  endfunction

  function automatic logic ref_ovf(input logic [63:0] p, input logic s);
    longint lo, hi;
    lo = -(longint'(1) <<< 31);
    hi = (longint'(1) <<< 31) - 1;
    if (s) return ($signed(p) < lo) || ($signed(p) > hi);
    return p > 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    int p;
    if (s) p = int'($signed(x)) * int'($signed(y));
    else   p = int'({24'b0, x}) * int'({24'b0, y});
    return 16'(p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the W=32 DUT; inputs are scrambled while busy.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input int stall, output logic [63:0] p, output logic ov,
                        output int lat);
    int guard;
    guard = 0;
    while (!mif.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!mif.in_ready) check("idle_timeout", 64'(mif.in_ready), 64'd1);
    mif.a = x; mif.b = y; mif.is_signed = s; mif.in_valid = 1'b1;
    tick();
    lat = 0;
    while (!mif.out_valid && lat < 4 * N) begin
      mif.a = $urandom; mif.b = $urandom;
      mif.is_signed = 1'($urandom); mif.in_valid = 1'($urandom);
      tick();
      lat++;
    end
    mif.in_valid = 1'b0;
    if (!mif.out_valid) check("done_timeout", 64'(mif.out_valid), 64'd1);
    for (int i = 0; i < stall; i++) tick();
    p = mif.product;
`ifdef MULT_SEQ_OVF_EN
    ov = mif.ovf;
`else
    ov = 1'b0;
`endif
    mif.out_ready = 1'b1;
    tick();
    mif.out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] p;
    logic        ov;
    int          lat;
    int          guard;
    int          k;
    int          bad;
    logic        seen;
    logic [31:0] x, y;
    logic        s;

    vecs[0] = '{32'd15,        32'd10,        1'b1, 64'd150,                 1'b0};
    vecs[1] = '{-32'sd25,      32'd12,        1'b1, -64'sd300,               1'b0};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1};
    vecs[4] = '{32'd3,         32'd5,         1'b0, 64'd15,                  1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1,                   1'b0};
    vecs[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, 1'b1};
    vecs[7] = '{32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000, 1'b1};
    vecs[8] = '{32'd0,         32'hDEAD_BEEF, 1'b1, 64'd0,                   1'b0};

    mif.in_valid = 1'b0; mif.out_ready = 1'b0;
    mif.a = '0; mif.b = '0; mif.is_signed = 1'b0;
    l_iv = 1'b0; l_or = 1'b0; l_s = 1'b0;
    for (int g = 0; g < L; g++) begin
      l_a[g] = '0;
      l_b[g] = '0;
    end

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_in_ready",  64'(mif.in_ready),  64'd1);
    check("reset_out_valid", 64'(mif.out_valid), 64'd0);
    check("reset_product",   mif.product,        64'd0);
`ifdef MULT_SEQ_OVF_EN
    check("reset_ovf",       64'(mif.ovf),       64'd0);
`endif

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, i % 3, p, ov, lat);
      check($sformatf("vec%0d_product", i), p, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(N));
`ifdef MULT_SEQ_OVF_EN
      check($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].ovf));
`endif
    end

    // Backpressure: product held through 10 stalled cycles with inputs churning.
    mif.a = 32'd7; mif.b = 32'd9; mif.is_signed = 1'b1; mif.in_valid = 1'b1;
    tick();
    mif.in_valid = 1'b0;
    guard = 0;
    while (!mif.out_valid && guard < 4 * N) begin
      tick();
      guard++;
    end
    check("bp_reach_done", 64'(mif.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      mif.a = $urandom; mif.b = $urandom;
      mif.is_signed = 1'($urandom); mif.in_valid = 1'b1;
      tick();
      check("bp_product",   mif.product,        64'd63);
      check("bp_out_valid", 64'(mif.out_valid), 64'd1);
      check("bp_in_ready",  64'(mif.in_ready),  64'd0);
    end
    mif.out_ready = 1'b1;
    tick();
    mif.out_ready = 1'b0;
    check("take_no_accept", 64'(mif.in_ready),  64'd1);
    check("take_out_valid", 64'(mif.out_valid), 64'd0);
    check("idle_hold",      mif.product,        64'd63);
    mif.in_valid = 1'b0;

    // Reset five cycles into an operation must discard it.
    mif.a = 32'd123; mif.b = 32'd456; mif.is_signed = 1'b0; mif.in_valid = 1'b1;
    tick();
    mif.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; mif.out_ready = 1'b1;
    tick();
    rst = 1'b0; mif.out_ready = 1'b0;
    check("abort_in_ready",  64'(mif.in_ready),  64'd1);
    check("abort_out_valid", 64'(mif.out_valid), 64'd0);
    check("abort_product",   mif.product,        64'd0);
    seen = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      tick();
      if (mif.out_valid) seen = 1'b1;
    end
    check("abort_never_valid", 64'(seen), 64'd0);
    run_op(-32'sd8, -32'sd8, 1'b1, 0, p, ov, lat);
    check("after_abort_product", p, 64'd64);

    for (int i = 0; i < 200; i++) begin
      x = $urandom; y = $urandom; s = 1'($urandom);
      case ($urandom_range(0, 7))
        0: x = 32'h8000_0000;
        1: y = 32'hFFFF_FFFF;
        2: x = 32'h0;
        default: ;
      endcase
      run_op(x, y, s, $urandom_range(0, 3), p, ov, lat);
      check("rand_product", p, ref_mul(x, y, s));
`ifdef MULT_SEQ_OVF_EN
      check("rand_ovf", 64'(ov), 64'(ref_ovf(ref_mul(x, y, s), s)));
`endif
    end

    // Exhaustive W=8 sweep, both modes.
    for (int m = 0; m < 2; m++) begin
      l_s = 1'(m);
      for (int batch = 0; batch < 65536 / L; batch++) begin
        for (int g = 0; g < L; g++) begin
          k = batch * L + g;
          l_a[g] = 8'(k >> 8);
          l_b[g] = 8'(k);
        end
        l_iv = 1'b1;
        tick();
        l_iv = 1'b0;
        guard = 0;
        while (!l_ov[0] && guard < 20) begin
          tick();
          guard++;
        end
        bad = 0;
        for (int g = L - 1; g >= 0; g--) begin
          if (!l_ov[g] || l_prod[g] !== ref8(l_a[g], l_b[g], l_s)) bad = g;
        end
        check("w8_sweep", {47'b0, l_ov[bad], l_prod[bad]},
              {47'b0, 1'b1, ref8(l_a[bad], l_b[bad], l_s)});
        l_or = 1'b1;
        tick();
        l_or = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplier_seq.md
MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

Interface
REQ-001 SHALL provide parameter W, default 32, operand width in bits; legal values are even and at least 4.
REQ-002 SHALL provide port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit, reset; synchronous, active-high.
REQ-004 SHALL provide port in_valid, input, 1 bit, operands present.
REQ-005 SHALL provide port in_ready, output, 1 bit, block can accept operands.
REQ-006 SHALL provide port a, input, W bits, multiplicand.
REQ-007 SHALL provide port b, input, W bits, multiplier.
REQ-008 SHALL provide port is_signed, input, 1 bit, operand mode: 1 = two's complement, 0 = unsigned.
REQ-009 SHALL provide port out_valid, output, 1 bit, product is available.
REQ-010 SHALL provide port out_ready, input, 1 bit, consumer takes the product.
REQ-011 SHALL provide port product, output, 2W bits, registered full-width result.

Function
REQ-012 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-014 SHALL accept an operation on an edge where in_valid && in_ready; on that edge it captures a, b and is_signed, clears the accumulator and the iteration counter, and moves IDLE -> BUSY.
REQ-015 SHALL ignore a, b and is_signed while in BUSY or DONE.
REQ-016 SHALL, in BUSY, retire one radix-4 Booth digit per cycle from b.
REQ-017 SHALL use W+2-bit operands for the Booth recoding: sign-extended when is_signed = 1, zero-extended when is_signed = 0.
REQ-018 SHALL run exactly N = W/2+1 iterations in both modes.
REQ-019 SHALL move BUSY -> DONE on the edge completing iteration N, and SHALL register product on that same edge.
REQ-020 SHALL give a latency where out_valid first goes high N cycles after the accept edge; for W=32, that is 17 cycles.
REQ-021 SHALL hold product and out_valid stable in DONE until out_valid && out_ready.
REQ-022 SHALL move DONE -> IDLE on the out_valid && out_ready edge; product keeps its last value in IDLE.
REQ-023 SHALL NOT accept a new operation in the cycle where the product is taken; peak throughput is one operation per N+2 cycles.
REQ-024 SHALL make product exactly equal to the mathematical a*b in 2W bits for all operand pairs; for signed -2^(W-1) * -2^(W-1) the result is +2^(2W-2), with no overflow.
REQ-025 SHALL treat out_ready as don't-care outside DONE, and in_valid as don't-care outside IDLE.

Reset
REQ-026 SHALL, on rst = 1 at a clock edge, enter IDLE and drive in_ready = 1, out_valid = 0 and product = 0 on the following cycle, with the counter and accumulator cleared.
REQ-027 SHALL, when rst is asserted during BUSY or DONE, abort the in-flight operation and never present its result.
REQ-028 SHALL give rst priority over any simultaneous in_valid or out_ready.

Configuration
REQ-029 SHALL recognise the macro MULT_SEQ_OVF_EN.
REQ-030 SHALL, with MULT_SEQ_OVF_EN defined, add output port ovf, 1 bit, valid with product. ovf = 1 when product does not fit in W bits of the operation's mode: signed when the upper W+1 bits are not all equal; unsigned when the upper W bits are not zero. ovf resets to 0 and is held with product.
REQ-031 SHALL, without MULT_SEQ_OVF_EN, have no ovf port and no related logic, with all other behaviour identical.

Verification
REQ-032 SHALL cover, at W=32 signed: 15 * 10 -> product = 150, with out_valid first high 17 cycles after the accept edge.
REQ-033 SHALL cover, at W=32 signed: -25 * 12 -> product = -300; and 0x80000000 * 0x80000000 -> product = 0x4000000000000000.
REQ-034 SHALL cover, at W=32 unsigned: 0xFFFFFFFF * 0xFFFFFFFF -> product = 0xFFFFFFFE00000001. With MULT_SEQ_OVF_EN, ovf = 1; 3 * 5 -> ovf = 0.
REQ-035 SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE, with a and b toggled meanwhile -> product and out_valid stable, in_ready = 0 throughout.
REQ-036 SHALL cover reset mid-operation: rst pulsed 5 cycles after accept -> next cycle in_ready = 1, out_valid = 0, product = 0. A new -8 * -8 then yields 64.
REQ-037 SHALL cover W=8 with an exhaustive sweep of all 65536 pairs in both modes, each product matching a reference model.
